// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer: decodes 0xFA frame headers, loads FrameData per payload word, then pulses one FrameStrobe bit.
// Optional error counter port err_cnt is built only when FRAME_SEQ_ERR_CNT_EN is defined.
module frame_strobe_sequencer #(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [31:0]                in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       busy,
   output logic                       err
`ifdef FRAME_SEQ_ERR_CNT_EN
   ,
   output logic [7:0]                 err_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, DATA, HOLD, STROBE} state_t;
   localparam logic [8:0] MAX_END = 9'(MaxFramesPerCol);
   state_t state, state_nx;
   logic [4:0] idx;
   logic [7:0] rem;
   logic [8:0] hdr_end;
   logic xfer, is_sync, hdr_ok, err_set, err_clr, unused_bits;
   assign in_ready = (state == IDLE) | (state == DATA);
   assign busy = state != IDLE;
   assign xfer = in_valid & in_ready;
   assign is_sync = in_data[31:24] == 8'hFA;
   assign hdr_end = {4'd0, in_data[4:0]} + {1'b0, in_data[15:8]};
   assign hdr_ok = is_sync && in_data[15:8] != 8'd0 && hdr_end <= MAX_END;
   assign err_clr = state == IDLE && xfer && is_sync && in_data[15:8] == 8'd0;
   assign err_set = state == IDLE && xfer && !hdr_ok && !err_clr;
   assign unused_bits = ^{in_data[23:16], in_data[7:5]};
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   state_nx = (xfer && hdr_ok) ? DATA : IDLE;
         DATA:   state_nx = xfer ? HOLD : DATA;
         HOLD:   state_nx = STROBE;
         STROBE: state_nx = (rem == 8'd1) ? IDLE : DATA;
         default: state_nx = IDLE;
      endcase
   end
   // Strobe is registered from the STROBE state, so it lands two edges after the payload load.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         idx         <= '0;
         rem         <= '0;
         FrameData   <= '0;
         FrameStrobe <= '0;
         err         <= 1'b0;
      end else begin
         if (state == IDLE && xfer && hdr_ok) begin
            idx <= in_data[4:0];
            rem <= in_data[15:8];
         end
         if (state == STROBE) begin
            idx <= idx + 5'd1;
            rem <= rem - 8'd1;
         end
         if (state == DATA && xfer) FrameData <= in_data;
         FrameStrobe <= (state == STROBE) ? MaxFramesPerCol'(1) << idx : '0;
         err <= err_set | (err & ~err_clr);
      end
   end
`ifdef FRAME_SEQ_ERR_CNT_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) err_cnt <= '0;
      else if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// tb_frame_strobe_sequencer: table-driven vectors plus hand sequences for backpressure, full range, reset and saturation.
module tb_frame_strobe_sequencer;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, busy, err;
   logic [31:0] FrameData;
   logic [19:0] FrameStrobe;
`ifdef FRAME_SEQ_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif
   int total = 0;
   int bad = 0;

   frame_strobe_sequencer dut (
      .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .err(err)
`ifdef FRAME_SEQ_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] d;
      logic        v;
      logic        rdy, bsy, er;
      logic [31:0] fd;
      logic [19:0] fs;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] d, input logic v);
      in_data = d;
      in_valid = v;
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [63:0] outs();
      return {9'd0, in_ready, busy, err, FrameData, FrameStrobe};
   endfunction

   initial begin
      // single write, range error, clear, 3-frame burst, bad sync, top index, header-looking payload, huge N
      tbl.push_back('{32'hFA000105, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        20'h0});
      tbl.push_back('{32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 20'h0});
      tbl.push_back('{32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 20'h0});
      tbl.push_back('{32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 20'h00020});
      tbl.push_back('{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 20'h0});
      tbl.push_back('{32'hFA000312, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 20'h0});
      tbl.push_back('{32'hFA000000, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 20'h0});
      tbl.push_back('{32'hFA000311, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 20'h0});
      tbl.push_back('{32'h1,        1'b1, 1'b0, 1'b1, 1'b0, 32'h1,        20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h1,        20'h0});
      tbl.push_back('{32'h2,        1'b1, 1'b1, 1'b1, 1'b0, 32'h1,        20'h20000});
      tbl.push_back('{32'h2,        1'b1, 1'b0, 1'b1, 1'b0, 32'h2,        20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h2,        20'h0});
      tbl.push_back('{32'h3,        1'b1, 1'b1, 1'b1, 1'b0, 32'h2,        20'h40000});
      tbl.push_back('{32'h3,        1'b1, 1'b0, 1'b1, 1'b0, 32'h3,        20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h3,        20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h3,        20'h80000});
      tbl.push_back('{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h3,        20'h0});
      tbl.push_back('{32'h12345678, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3,        20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h3,        20'h0});
      tbl.push_back('{32'hFA000000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h3,        20'h0});
      tbl.push_back('{32'hFA000113, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3,        20'h0});
      tbl.push_back('{32'hAAAA5555, 1'b1, 1'b0, 1'b1, 1'b0, 32'hAAAA5555, 20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA5555, 20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA5555, 20'h80000});
      tbl.push_back('{32'hFA000100, 1'b1, 1'b1, 1'b1, 1'b0, 32'hAAAA5555, 20'h0});
      tbl.push_back('{32'hFA000312, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFA000312, 20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hFA000312, 20'h0});
      tbl.push_back('{32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hFA000312, 20'h00001});
      tbl.push_back('{32'hFA00FF00, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFA000312, 20'h0});
      tbl.push_back('{32'hFA000000, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFA000312, 20'h0});

      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      check("reset", outs(), {9'd0, 1'b1, 1'b0, 1'b0, 32'h0, 20'h0});
`ifdef FRAME_SEQ_ERR_CNT_EN
      check("reset_cnt", 64'(err_cnt), 64'd0);
`endif

      foreach (tbl[i]) begin
         drive(tbl[i].d, tbl[i].v);
         check($sformatf("vec%0d", i), outs(),
               {9'd0, tbl[i].rdy, tbl[i].bsy, tbl[i].er, tbl[i].fd, tbl[i].fs});
      end
`ifdef FRAME_SEQ_ERR_CNT_EN
      check("cnt_after_clear", 64'(err_cnt), 64'd3);
`endif

      // backpressure: N=2 at I=2 with a 10-cycle gap between payloads
      drive(32'hFA000202, 1'b1);
      drive(32'hA1, 1'b1);
      check("bp_fd1", 64'(FrameData), 64'hA1);
      drive(32'h0, 1'b0);
      drive(32'h0, 1'b0);
      check("bp_fs1", 64'(FrameStrobe), 64'h4);
      for (int k = 0; k < 10; k++) begin
         drive(32'h0, 1'b0);
         check($sformatf("bp_wait%0d", k), outs(), {9'd0, 1'b1, 1'b1, 1'b0, 32'hA1, 20'h0});
      end
      drive(32'hB2, 1'b1);
      check("bp_fd2", outs(), {9'd0, 1'b0, 1'b1, 1'b0, 32'hB2, 20'h0});
      drive(32'h0, 1'b0);
      check("bp_gap", 64'(FrameStrobe), 64'h0);
      drive(32'h0, 1'b0);
      check("bp_fs2", outs(), {9'd0, 1'b1, 1'b0, 1'b0, 32'hB2, 20'h8});

      // full column: I=0, N=20 strobes every line in order
      drive(32'hFA001400, 1'b1);
      for (int k = 0; k < 20; k++) begin
         drive(32'h100 + 32'(k), 1'b1);
         check($sformatf("full_fd%0d", k), 64'(FrameData), 64'h100 + 64'(k));
         drive(32'h0, 1'b0);
         drive(32'h0, 1'b0);
         check($sformatf("full_fs%0d", k), 64'(FrameStrobe), 64'(20'(1) << k));
      end
      check("full_idle", {62'd0, in_ready, busy}, 64'b10);

      // asynchronous reset while a strobe is high, remaining frame abandoned
      drive(32'hFA000200, 1'b1);
      drive(32'h55, 1'b1);
      drive(32'h0, 1'b0);
      drive(32'h0, 1'b0);
      check("rst_pre", 64'(FrameStrobe), 64'h1);
      #2 RESET = 1'b1;
      #1 check("rst_async", outs(), {9'd0, 1'b1, 1'b0, 1'b0, 32'h0, 20'h0});
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(32'h0, 1'b0);
         check($sformatf("rst_after%0d", k), outs(), {9'd0, 1'b1, 1'b0, 1'b0, 32'h0, 20'h0});
      end
      drive(32'hFA000101, 1'b1);
      drive(32'h77, 1'b1);
      drive(32'h0, 1'b0);
      check("rst_new_hold", 64'(FrameStrobe), 64'h0);
      drive(32'h0, 1'b0);
      check("rst_new_fs", outs(), {9'd0, 1'b1, 1'b0, 1'b0, 32'h77, 20'h2});

`ifdef FRAME_SEQ_ERR_CNT_EN
      repeat (300) drive(32'h12345678, 1'b1);
      drive(32'h0, 1'b0);
      check("sat_cnt", 64'(err_cnt), 64'd255);
      check("sat_err", 64'(err), 64'd1);
      drive(32'hFA000000, 1'b1);
      check("sat_clear", {55'd0, err, err_cnt}, {55'd0, 1'b0, 8'd255});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
